// File: rtl/econet_tx_queue.sv
// econet_tx_queue: multi-frame Econet transmit queue (circular byte buffer, descriptor FIFO, HDLC FCS).
// Optional collision retry with backoff is built when ECO_TX_RETRY_EN is defined.
module econet_tx_queue #(
`ifdef ECO_TX_RETRY_EN
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 64,
`endif
    parameter int BUF_BYTES = 1024,
    parameter int ADDR_W    = 10,
    parameter int QDEPTH    = 4,
    parameter int QPTR_W    = 2
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              sys_select,
    input  logic [3:0]        sys_we,
    input  logic [ADDR_W-3:0] sys_addr,
    input  logic [31:0]       sys_data,
    input  logic              sys_select_desc,
    input  logic              sys_select_stat,
    output logic [31:0]       status,
    output logic [7:0]        tx_byte,
    output logic              start_frame,
    output logic              end_frame,
    input  logic              request_byte,
    input  logic              transmitting,
    input  logic              receiving,
    input  logic              abort,
`ifdef ECO_TX_RETRY_EN
    input  logic              collision,
`endif
    output logic              busy,
    output logic              queue_full,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RXWAIT  = 3'd1,
        S_START   = 3'd2,
        S_TX      = 3'd3,
        S_FCS1    = 3'd4,
        S_FCS2    = 3'd5,
        S_DONE    = 3'd6,
        S_BACKOFF = 3'd7
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   ptr;
    logic [15:0]         crc;
    logic [3:0][7:0]     buf_mem [BUF_BYTES/4];
    logic [3:0][7:0]     rd_word;
    logic [1:0]          rd_lane;
    logic [ADDR_W-1:0]   q_start [QDEPTH];
    logic [ADDR_W-1:0]   q_end   [QDEPTH];
    logic [QPTR_W-1:0]   q_wr, q_rd;
    logic [QPTR_W:0]     q_count;
    logic                push_req, push_ok, pop, stat_clr;
    logic                load_frame, absorb, advance, done_ok, active;
    logic                overflow, retry_fail;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    assign push_req   = sys_select_desc && (sys_we != 4'b0000);
    assign stat_clr   = sys_select_stat && (sys_we != 4'b0000);
    assign queue_full = (q_count == (QPTR_W+1)'(QDEPTH));
    assign push_ok    = push_req && (!queue_full || pop);
    assign busy       = (state != S_IDLE) || (q_count != '0) || transmitting;

    // NOTE: buffer and descriptor storage are never reset; only their pointers and counters are.
    always_ff @(posedge sys_clk) begin
        if (sys_select)
            for (int i = 0; i < 4; i++)
                if (sys_we[i]) buf_mem[sys_addr][i] <= sys_data[8*i +: 8];
        rd_word <= buf_mem[ptr[ADDR_W-1:2]];
        rd_lane <= ptr[1:0];
        if (push_ok) begin
            q_start[q_wr] <= sys_data[ADDR_W-1:0];
            q_end[q_wr]   <= sys_data[16 +: ADDR_W];
        end
    end

`ifdef ECO_TX_RETRY_EN
    localparam int BO_W = $clog2(BACKOFF + 1);
    localparam int RT_W = $clog2(MAX_RETRY + 1);
    logic [BO_W-1:0] bo_cnt;
    logic [RT_W-1:0] retry_cnt;
    logic            coll_hit, retry_exhaust;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        tx_byte     = 8'h00;
        pop         = 1'b0;
        absorb      = 1'b0;
        advance     = 1'b0;
        done_ok     = 1'b0;
        load_frame  = 1'b0;
        active      = state inside {S_START, S_TX, S_FCS1, S_FCS2};
`ifdef ECO_TX_RETRY_EN
        coll_hit      = 1'b0;
        retry_exhaust = 1'b0;
`endif
        case (state)
            S_IDLE:   if (q_count != '0) state_next = receiving ? S_RXWAIT : S_START;
            S_RXWAIT: if (!receiving) state_next = S_START;
            S_START: begin
                start_frame = 1'b1;
                state_next  = S_TX;
            end
            S_TX: begin
                tx_byte = rd_word[rd_lane];
                if (request_byte) begin
                    absorb = 1'b1;
                    if (ptr == q_end[q_rd]) state_next = S_FCS1;
                    else                    advance    = 1'b1;
                end
            end
            S_FCS1: begin
                tx_byte = ~crc[7:0];
                if (request_byte) state_next = S_FCS2;
            end
            S_FCS2: begin
                tx_byte   = ~crc[15:8];
                end_frame = 1'b1;
                if (request_byte) begin
                    state_next = S_DONE;
                    done_ok    = 1'b1;
                end
            end
            S_DONE: begin
                pop        = 1'b1;
                state_next = S_IDLE;
            end
`ifdef ECO_TX_RETRY_EN
            S_BACKOFF: if (bo_cnt == '0) state_next = S_START;
`endif
            default: state_next = S_IDLE;
        endcase

        // Abort outranks collision; both close the frame on the line immediately.
        if (active && abort) begin
            end_frame  = 1'b1;
            state_next = S_DONE;
            absorb     = 1'b0;
            advance    = 1'b0;
            done_ok    = 1'b0;
        end
`ifdef ECO_TX_RETRY_EN
        else if (active && collision) begin
            end_frame = 1'b1;
            absorb    = 1'b0;
            advance   = 1'b0;
            done_ok   = 1'b0;
            if (retry_cnt == RT_W'(MAX_RETRY)) begin
                retry_exhaust = 1'b1;
                state_next    = S_DONE;
            end else begin
                coll_hit   = 1'b1;
                state_next = S_BACKOFF;
            end
        end
`endif
        load_frame = (state_next == S_START);
    end

    // NOTE: sequential state uses non-blocking assignments; blocking is kept to the CRC function and comb logic.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            crc        <= 16'hFFFF;
            frame_done <= 1'b0;
            q_wr       <= '0;
            q_rd       <= '0;
            q_count    <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= done_ok;
            if (load_frame) begin
                ptr <= q_start[q_rd];
                crc <= 16'hFFFF;
            end else begin
                if (absorb)  crc <= crc_byte(crc, tx_byte);
                if (advance) ptr <= ptr + 1'b1;
            end
            if (push_ok) q_wr <= q_wr + 1'b1;
            if (pop)     q_rd <= q_rd + 1'b1;
            case ({push_ok, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: ;
            endcase
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (stat_clr)        overflow <= 1'b0;
        end
    end

`ifdef ECO_TX_RETRY_EN
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            bo_cnt     <= '0;
            retry_cnt  <= '0;
            retry_fail <= 1'b0;
        end else begin
            if (coll_hit) begin
                bo_cnt    <= BO_W'(BACKOFF - 1);
                retry_cnt <= retry_cnt + 1'b1;
            end else if (state == S_BACKOFF) begin
                bo_cnt <= bo_cnt - 1'b1;
            end
            if (state == S_DONE) retry_cnt <= '0;
            if (retry_exhaust)   retry_fail <= 1'b1;
            else if (stat_clr)   retry_fail <= 1'b0;
        end
    end
`else
    assign retry_fail = 1'b0;
`endif

    always_comb begin
        status                = '0;
        status[31]            = overflow;
        status[30]            = retry_fail;
        status[QPTR_W+8:8]    = q_count;
        status[2:0]           = state;
    end

endmodule
